snow_keystream_out: RTL
=======================

// Module: snow_keystream_out
// PURPOSE
//   Downstream consumer of the SNOW 2.0 mod-2^32 adder. Forms FSM output F = sum ^ R2.
//   Init: F is returned to the LFSR as feedback, then one output word is discarded.
//   Run: z = F ^ s0 is buffered and delivered over a valid/ready handshake.
//   Paces LFSR/FSM stepping (lfsr_adv) by credits so no in-flight word is ever dropped.
// PARAMETERS
//   FIFO_DEPTH   4   keystream buffer entries (power of 2, >=2)
//   INIT_ROUNDS  32  feedback words consumed in INIT (SNOW 2.0 = 32)
// PORTS
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous, active-low reset
//   start      in   1   pulse: begin key/IV initialisation
//   sum        in   32  adder result (s15 + R1) mod 2^32
//   sum_vld    in   1   sum, r2, s0 valid (aligned upstream)
//   r2         in   32  FSM R2 aligned with sum
//   s0         in   32  LFSR s0 aligned with sum
//   lfsr_adv   out  1   step LFSR/FSM one clock this cycle
//   fb_word    out  32  init feedback F = sum ^ r2
//   fb_vld     out  1   fb_word valid (INIT only)
//   z          out  32  keystream word (FIFO head)
//   z_valid    out  1   FIFO non-empty
//   z_ready    in   1   consumer accepts z
//   busy       out  1   state != IDLE
//   err        out  1   sticky: sum_vld with zero outstanding
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; every output 0; FIFO empty; counters 0.
//   FSM states: IDLE -> INIT -> DISCARD -> RUN. RUN exits only via reset or start.
//   outstanding: +1 on lfsr_adv, -1 on sum_vld; both in one cycle => unchanged.
//     Never exceeds FIFO_DEPTH.
//   start: accepted only when outstanding==0; otherwise ignored.
//     Acceptance flushes the FIFO, clears round_cnt and err, state <= INIT.
//   INIT: lfsr_adv=1 only when outstanding==0 and round_cnt<INIT_ROUNDS.
//     Feedback must land before the next LFSR step.
//     On sum_vld: fb_word<=sum^r2, fb_vld=1 for exactly 1 cycle (registered, 1-cycle latency);
//     round_cnt++. When round_cnt reaches INIT_ROUNDS with outstanding==0: state <= DISCARD.
//   DISCARD: issue one lfsr_adv. The resulting sum_vld word is dropped: no fb, no FIFO write.
//     State <= RUN the cycle after that sum_vld.
//   RUN: lfsr_adv=1 when (fifo_count + outstanding) < FIFO_DEPTH.
//     On sum_vld: push sum^r2^s0; z_valid is high the cycle after the push (latency 1).
//   FIFO: pop on z_valid&z_ready; z is held stable while z_valid&!z_ready.
//     Simultaneous push+pop keeps count; push to a full FIFO cannot occur (credit rule).
//     Push and pop pointers wrap modulo FIFO_DEPTH.
//   fb_vld is never asserted outside INIT; z_valid never before RUN.
//   sum_vld when outstanding==0: word ignored, err<=1 (held until reset/start).
//   XOR only; no arithmetic carries. All data 32 bits; no truncation.
//   busy = (state!=IDLE). IDLE ignores sum_vld except for the err rule.
// TESTING
//   1 Reset mid-RUN with 3 words buffered -> next cycle z_valid=0, lfsr_adv=0, busy=0,
//     z=0, fb_vld=0.
//   2 start; model returns sum=0x00000001, r2=0x80000000 after 3 cycles per adv
//     -> 32 fb_vld pulses, each fb_word=0x80000001; one adv per outstanding==0.
//   3 DISCARD: sum=0xDEADBEEF, r2=0, s0=0 -> no fb_vld, no FIFO entry; RUN next cycle.
//   4 RUN, z_ready=0: sum=0xFFFFFFFF, r2=0x0F0F0F0F, s0=0x00FF00FF
//     -> z=0xF00FF00F held; lfsr_adv stops after 4 credits; then ready=1 drains 4 in order.
//   5 RUN, z_ready=1 throughout, adder latency 1 -> one word per cycle, no gaps/drops;
//     simultaneous push+pop keeps count steady.
//   6 start while outstanding=2 -> ignored (state unchanged).
//     Stray sum_vld in IDLE -> err=1; next accepted start clears err.

Source files
------------

// File: rtl/snow_keystream_out.sv
// SNOW 2.0 keystream output stage.
// Forms F = sum ^ r2 from the adder result. During INIT, F goes back to the LFSR
// as feedback. One word is then discarded. In RUN, z = F ^ s0 is buffered and
// handed to the consumer. lfsr_adv is issued against credits so that every word
// already in flight always has somewhere to land.
module snow_keystream_out #(
    parameter int FIFO_DEPTH  = 4,
    parameter int INIT_ROUNDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] sum,
    input  logic        sum_vld,
    input  logic [31:0] r2,
    input  logic [31:0] s0,
    output logic        lfsr_adv,
    output logic [31:0] fb_word,
    output logic        fb_vld,
    output logic [31:0] z,
    output logic        z_valid,
    input  logic        z_ready,
    output logic        busy,
    output logic        err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int RW = $clog2(INIT_ROUNDS + 1);
    localparam logic [CW:0]   DEPTH_V  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [RW-1:0] ROUNDS_V = RW'(INIT_ROUNDS);

    typedef enum logic [1:0] {IDLE, INIT, DISCARD, RUN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [RW-1:0] round_cnt;
    logic          disc_issued;
    logic [31:0]   mem [FIFO_DEPTH];

    logic          start_acc;
    logic          word_acc;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;

    // A word from the adder is only genuine when a step is outstanding.
    // A restart is only safe when nothing is still in flight.
    assign start_acc   = start && (outstanding == '0);
    assign word_acc    = sum_vld && (outstanding != '0);
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    assign push        = word_acc && (state == RUN);
    assign pop         = z_valid && z_ready;

    assign z_valid = (fifo_count != '0);
    assign z       = z_valid ? mem[rd_ptr] : 32'h0;
    assign busy    = (state != IDLE);

    // Next-state and LFSR stepping decision.
    // An accepted start suppresses stepping, so INIT begins with nothing in flight.
    always_comb begin
        state_nxt = state;
        lfsr_adv  = 1'b0;
        case (state)
            IDLE: begin
                lfsr_adv = 1'b0;
            end
            INIT: begin
                lfsr_adv = (outstanding == '0) && (round_cnt < ROUNDS_V);
                if ((round_cnt == ROUNDS_V) && (outstanding == '0))
                    state_nxt = DISCARD;
            end
            DISCARD: begin
                lfsr_adv = !disc_issued;
                if (word_acc)
                    state_nxt = RUN;
            end
            RUN: begin
                lfsr_adv = (credit_used < DEPTH_V);
            end
            default: state_nxt = IDLE;
        endcase
        if (start_acc) begin
            state_nxt = INIT;
            lfsr_adv  = 1'b0;
        end
    end

    // Control state: FSM, in-flight count, round counter, error flag and feedback register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            outstanding <= '0;
            round_cnt   <= '0;
            disc_issued <= 1'b0;
            err         <= 1'b0;
            fb_vld      <= 1'b0;
            fb_word     <= 32'h0;
        end else begin
            state  <= state_nxt;
            fb_vld <= 1'b0;

            if (lfsr_adv && !word_acc)
                outstanding <= outstanding + 1'b1;
            else if (!lfsr_adv && word_acc)
                outstanding <= outstanding - 1'b1;

            if (start_acc)
                round_cnt <= '0;
            else if ((state == INIT) && word_acc)
                round_cnt <= round_cnt + 1'b1;

            if (start_acc)
                disc_issued <= 1'b0;
            else if ((state == DISCARD) && lfsr_adv)
                disc_issued <= 1'b1;

            if (start_acc)
                err <= 1'b0;
            else if (sum_vld && (outstanding == '0))
                err <= 1'b1;

            if ((state == INIT) && word_acc) begin
                fb_vld  <= 1'b1;
                fb_word <= sum ^ r2;
            end
        end
    end

    // Keystream FIFO bookkeeping. Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (start_acc) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (!push && pop)
                fifo_count <= fifo_count - 1'b1;
        end
    end

    // Keystream storage. No reset is needed because z is gated by z_valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= sum ^ r2 ^ s0;
    end

endmodule
